bin2bcd_seq: RTL and testbench

Iterative shift-add-3 (double-dabble) converter that turns an unsigned binary value into packed BCD digits.
Sits directly upstream of the 7-segment digit decoders: each 4-bit nibble of out_bcd drives one decoder instance.
Uses a valid/ready handshake on both sides and holds its result stable for the display while the next conversion runs.

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/dd_adjust_digit.sv | 18 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits per packed BCD digit.
    localparam int unsigned BCD_DIGIT_W = 4;

    // Number of decimal digits needed to print 2^width-1.
    function automatic int unsigned bcd_digits_needed(input int unsigned width);
        longint unsigned max_val;
        int unsigned     n;
        max_val = (64'd1 << width) - 64'd1;
        n       = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n       = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/dd_adjust_digit.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module dd_adjust_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // 4-bit add with no carry out; inputs are always 0..9 in practice.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter from unsigned binary to packed BCD.
// One bit is consumed per clock; the last result stays on out_bcd for the
// display while the next conversion is in progress.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd
);

    localparam int unsigned BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int unsigned WORK_W = BCD_W + WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject parameter sets the datapath cannot represent.
    if (WIDTH == 0 || WIDTH > 16) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be in 1..16");
    end
    if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
    end

    state_e           state_q, state_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] out_bcd_q, out_bcd_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [WORK_W-1:0] work_shl;

    // Per-digit add-3 correction on the accumulator.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        dd_adjust_digit u_adj (
            .digit_i (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected work register shifted left by one; MSB of bin enters the units digit.
    always_comb begin
        work_shl = {bcd_adj, bin_q} << 1;
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = SHIFT;
                    bcd_d   = '0;
                    bin_d   = in_bin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                bcd_d = work_shl[WORK_W-1 -: BCD_W];
                bin_d = work_shl[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                // Publish only a finished result so the display never sees partial digits.
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    out_bcd_d = work_shl[WORK_W-1 -: BCD_W];
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
        end
    end

    assign out_bcd = out_bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an 8-bit/3-digit instance for the main
// scenarios and a 10-bit/4-digit instance for the wider configuration.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_bin8 = '0;
    logic        out_valid8;
    logic        out_ready8 = 1'b1;
    logic [11:0] out_bcd8;

    logic        in_valid10 = 1'b0;
    logic        in_ready10;
    logic [9:0]  in_bin10 = '0;
    logic        out_valid10;
    logic        out_ready10 = 1'b1;
    logic [15:0] out_bcd10;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_bin    (in_bin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_bcd   (out_bcd8)
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid10),
        .in_ready  (in_ready10),
        .in_bin    (in_bin10),
        .out_valid (out_valid10),
        .out_ready (out_ready10),
        .out_bcd   (out_bcd10)
    );

    typedef struct {
        logic [15:0] bcd;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q10[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits by plain arithmetic, packed four bits per digit.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          rem;
        r   = '0;
        rem = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic send(input int which, input int v);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        if (which == 8) begin
            in_valid8 = 1'b1;
            in_bin8   = 8'(v);
        end else begin
            in_valid10 = 1'b1;
            in_bin10   = 10'(v);
        end
        forever begin
            #1;
            if ((which == 8) ? in_ready8 : in_ready10) break;
            if (waited > 300) begin
                n_chk++;
                n_fail++;
                $display("FAIL accept_timeout: dut%0d never ready for %0d", which, v);
                break;
            end
            waited++;
            @(negedge clk);
        end
        e.bcd    = ref_bcd(v);
        e.acc    = cyc + 1;
        last_acc = e.acc;
        if (which == 8) q8.push_back(e);
        else            q10.push_back(e);
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid10 = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((q8.size() != 0 || q10.size() != 0 || out_valid8 || out_valid10 ||
                !in_ready8 || !in_ready10) && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: q8=%0d q10=%0d pending", q8.size(), q10.size());
        end
    endtask

    // Randomised consumer backpressure for the 8-bit instance.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready8 = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the 8-bit instance: new results, latency, hold and BCD legality.
    initial begin : mon8
        bit          have;
        logic [15:0] cur;
        exp_t        e;
        have = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                have = 1'b0;
                continue;
            end
            chk("ready_valid_excl8", 32'(in_ready8 & out_valid8), 0);
            for (int k = 0; k < 3; k++) begin
                chk("nibble_bcd8", 32'(out_bcd8[4*k +: 4] > 4'd9), 0);
            end
            if (out_valid8) begin
                if (!have) begin
                    if (q8.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected8: got %0h, expected no result", out_bcd8);
                    end else begin
                        e = q8.pop_front();
                        chk("bcd8", 32'(out_bcd8), 32'(e.bcd));
                        chk("latency8", cyc, e.acc + 8);
                        cur = e.bcd;
                    end
                    have = 1'b1;
                end else begin
                    chk("hold8", 32'(out_bcd8), 32'(cur));
                end
                if (out_ready8) have = 1'b0;
            end
        end
    end

    // Monitor for the 10-bit instance.
    initial begin : mon10
        bit   have;
        exp_t e;
        have = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                have = 1'b0;
                continue;
            end
            chk("ready_valid_excl10", 32'(in_ready10 & out_valid10), 0);
            if (out_valid10 && !have) begin
                if (q10.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected10: got %0h, expected no result", out_bcd10);
                end else begin
                    e = q10.pop_front();
                    chk("bcd10", 32'(out_bcd10), 32'(e.bcd));
                    chk("latency10", cyc, e.acc + 10);
                end
                have = 1'b1;
            end
            if (out_valid10 && out_ready10) have = 1'b0;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a17;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready8), 1);
        chk("rst_out_valid", 32'(out_valid8), 0);
        chk("rst_out_bcd", 32'(out_bcd8), 0);

        // Zero input: full WIDTH iterations, busy throughout SHIFT/DONE
        send(8, 0);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            #1;
            chk("busy_in_ready", 32'(in_ready8), 0);
            chk("zero_latency_valid", 32'(out_valid8), (i == 8) ? 1 : 0);
        end
        wait_drain();

        // Exhaustive sweep with the consumer always ready
        for (int v = 0; v < 256; v++) send(8, v);
        wait_drain();

        // Backpressure: result held while out_ready is low
        out_ready8 = 1'b0;
        send(8, 173);
        begin
            int w;
            w = 0;
            while (!out_valid8 && w < 50) begin
                @(negedge clk);
                #1;
                w++;
            end
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("stall_valid", 32'(out_valid8), 1);
            chk("stall_bcd", 32'(out_bcd8), 32'h173);
        end
        @(negedge clk);
        out_ready8 = 1'b1;
        @(negedge clk);
        #1;
        chk("release_valid", 32'(out_valid8), 0);
        chk("release_ready", 32'(in_ready8), 1);
        wait_drain();

        // Second request held during SHIFT is taken only once back in IDLE
        send(8, 17);
        a17 = last_acc;
        send(8, 42);
        chk("deferred_accept", last_acc - a17, 10);
        wait_drain();

        // Reset mid-conversion discards the work and clears the output
        send(8, 250);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready8), 1);
        chk("midrst_out_valid", 32'(out_valid8), 0);
        chk("midrst_out_bcd", 32'(out_bcd8), 0);
        send(8, 7);
        wait_drain();

        // Random values with random gaps and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8, int'($urandom_range(0, 255)));
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready8 = 1'b1;
        wait_drain();

        // Wider configuration: maximum value and a few others
        send(10, 1023);
        send(10, 0);
        send(10, 512);
        for (int i = 0; i < 20; i++) send(10, int'($urandom_range(0, 1023)));
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
